// File: rtl/flash_timer.sv
// One-shot / auto-reload down-counting timer with registered busy, done, expired and count.
// Define FLASH_TIMER_PRESCALE_EN to build a PRESCALE-cycle tick prescaler; otherwise it ticks every cycle.
module flash_timer #(
    parameter int CNT_W    = 8,
    parameter int PERIODIC = 0,
    parameter int PRESCALE = 50
) (
    input  logic             CLK_50MHZ,
    input  logic             RST,
    input  logic             start,
    input  logic [CNT_W-1:0] delay,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             expired,
    output logic [CNT_W-1:0] count
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] delay_q;
    logic             tick;

`ifdef FLASH_TIMER_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;

    assign tick = (pre_cnt == PRE_LAST);

    // Held at zero outside RUN, so an accepted start always begins a fresh PRESCALE window.
    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            pre_cnt <= '0;
        end else if (state == IDLE || abort || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Expiry is the tick seen while count is already zero; abort is checked first so it wins.
    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            expired <= 1'b0;
            count   <= '0;
            delay_q <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (abort) begin
                        expired <= 1'b0;
                        count   <= '0;
                    end else if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        expired <= 1'b0;
                        count   <= delay;
                        delay_q <= delay;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        expired <= 1'b0;
                        count   <= '0;
                    end else if (tick) begin
                        if (count == '0) begin
                            done    <= 1'b1;
                            expired <= 1'b1;
                            if (PERIODIC != 0) begin
                                count <= delay_q;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_timer.sv
// Bench for flash_timer: one-shot and periodic instances share stimulus and are checked
// against an elapsed-tick reference model, a vector table and a few timing sequences.
module tb_flash_timer;

`ifdef FLASH_TIMER_PRESCALE_EN
    localparam int TB_PRESCALE = 50;
    localparam int TICK_P      = 50;
`else
    localparam int TB_PRESCALE = 50;
    localparam int TICK_P      = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] delay = '0;

    logic       os_busy, os_done, os_expired;
    logic [7:0] os_count;
    logic       per_busy, per_done, per_expired;
    logic [7:0] per_count;

    int tests_run = 0;
    int tests_failed = 0;

    always #10 clk = ~clk;

    flash_timer #(.CNT_W(8), .PERIODIC(0), .PRESCALE(TB_PRESCALE)) u_oneshot (
        .CLK_50MHZ(clk), .RST(rst), .start(start), .delay(delay), .abort(abort),
        .busy(os_busy), .done(os_done), .expired(os_expired), .count(os_count)
    );

    flash_timer #(.CNT_W(8), .PERIODIC(1), .PRESCALE(TB_PRESCALE)) u_periodic (
        .CLK_50MHZ(clk), .RST(rst), .start(start), .delay(delay), .abort(abort),
        .busy(per_busy), .done(per_done), .expired(per_expired), .count(per_count)
    );

    // Reference model: index 0 is one-shot, 1 is periodic. Count is derived from ticks elapsed since start.
    int m_run[2], m_d[2], m_cyc[2], m_busy[2], m_done[2], m_exp[2], m_count[2];

    task automatic modelStep();
        int ph;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_run[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_exp[i] = 0; m_count[i] = 0;
            end else if (m_run[i] == 0) begin
                m_done[i] = 0;
                if (abort) begin
                    m_exp[i] = 0; m_count[i] = 0;
                end else if (start) begin
                    m_run[i] = 1; m_busy[i] = 1; m_exp[i] = 0;
                    m_d[i] = int'(delay); m_cyc[i] = 0; m_count[i] = int'(delay);
                end
            end else begin
                m_cyc[i]++;
                m_done[i] = 0;
                if (abort) begin
                    m_run[i] = 0; m_busy[i] = 0; m_exp[i] = 0; m_count[i] = 0;
                end else if (m_cyc[i] % TICK_P == 0) begin
                    ph = (m_cyc[i] / TICK_P) % (m_d[i] + 1);
                    if (ph == 0) begin
                        m_done[i] = 1; m_exp[i] = 1;
                        if (i == 0) begin
                            m_run[i] = 0; m_busy[i] = 0; m_count[i] = 0;
                        end else begin
                            m_count[i] = m_d[i];
                        end
                    end else begin
                        m_count[i] = m_d[i] - ph;
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        check("model oneshot busy",    32'(os_busy),     32'(m_busy[0]));
        check("model oneshot done",    32'(os_done),     32'(m_done[0]));
        check("model oneshot expired", 32'(os_expired),  32'(m_exp[0]));
        check("model oneshot count",   32'(os_count),    32'(m_count[0]));
        check("model periodic busy",   32'(per_busy),    32'(m_busy[1]));
        check("model periodic done",   32'(per_done),    32'(m_done[1]));
        check("model periodic expired",32'(per_expired), 32'(m_exp[1]));
        check("model periodic count",  32'(per_count),   32'(m_count[1]));
    endtask

    // Inputs are held across the edge; model and DUTs see the same values, outputs sampled 1 time unit later.
    task automatic applyStimulus(input logic r, input logic s, input logic a, input logic [7:0] d);
        rst = r; start = s; abort = a; delay = d;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    typedef struct {
        logic       rst, start, abort;
        logic [7:0] delay;
        logic       busy, done, expired;
        logic [7:0] count;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic r, input logic s, input logic a, input logic [7:0] d,
                                input logic b, input logic dn, input logic e, input logic [7:0] c);
        vec_t v;
        v.rst = r; v.start = s; v.abort = a; v.delay = d;
        v.busy = b; v.done = dn; v.expired = e; v.count = c;
        return v;
    endfunction

    initial begin
        logic r, s, a;
        logic [7:0] d;

        vecs[0]  = mk(1, 0, 0, 8'd0, 0, 0, 0, 8'd0);
        vecs[1]  = mk(0, 1, 0, 8'd7, 1, 0, 0, 8'd7);
        for (int i = 2; i <= 8; i++) vecs[i] = mk(0, 0, 0, 8'd0, 1, 0, 0, 8'(8 - i));
        vecs[9]  = mk(0, 0, 0, 8'd0, 0, 1, 1, 8'd0);
        vecs[10] = mk(0, 0, 0, 8'd0, 0, 0, 1, 8'd0);
        vecs[11] = mk(0, 1, 0, 8'd0, 1, 0, 0, 8'd0);
        vecs[12] = mk(0, 0, 0, 8'd0, 0, 1, 1, 8'd0);
        vecs[13] = mk(0, 1, 0, 8'd0, 1, 0, 0, 8'd0);
        vecs[14] = mk(0, 0, 0, 8'd0, 0, 1, 1, 8'd0);
        vecs[15] = mk(0, 0, 1, 8'd0, 0, 0, 0, 8'd0);
        vecs[16] = mk(0, 1, 1, 8'd5, 0, 0, 0, 8'd0);
        vecs[17] = mk(0, 0, 0, 8'd0, 0, 0, 0, 8'd0);

        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_d[i] = 0; m_cyc[i] = 0; m_busy[i] = 0;
            m_done[i] = 0; m_exp[i] = 0; m_count[i] = 0;
        end

`ifndef FLASH_TIMER_PRESCALE_EN
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].abort, vecs[i].delay);
            check($sformatf("vec%0d busy", i),    32'(os_busy),    32'(vecs[i].busy));
            check($sformatf("vec%0d done", i),    32'(os_done),    32'(vecs[i].done));
            check($sformatf("vec%0d expired", i), 32'(os_expired), 32'(vecs[i].expired));
            check($sformatf("vec%0d count", i),   32'(os_count),   32'(vecs[i].count));
        end

        // Periodic D=3 with abort on edge +10.
        applyStimulus(1, 0, 0, 8'd0);
        applyStimulus(0, 1, 0, 8'd3);
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(0, 0, (k == 10), 8'd0);
            check($sformatf("periodic done@%0d", k), 32'(per_done), 32'((k == 4 || k == 8) ? 1 : 0));
            if (k >= 10) check($sformatf("periodic busy@%0d", k), 32'(per_busy), 32'd0);
            if (k < 10)  check($sformatf("periodic busy@%0d", k), 32'(per_busy), 32'd1);
        end

        // Abort on the expiry edge.
        applyStimulus(1, 0, 0, 8'd0);
        applyStimulus(0, 1, 0, 8'd2);
        applyStimulus(0, 0, 0, 8'd0);
        applyStimulus(0, 0, 0, 8'd0);
        applyStimulus(0, 0, 1, 8'd0);
        check("abort-expiry oneshot done",     32'(os_done),     32'd0);
        check("abort-expiry oneshot expired",  32'(os_expired),  32'd0);
        check("abort-expiry oneshot busy",     32'(os_busy),     32'd0);
        check("abort-expiry periodic done",    32'(per_done),    32'd0);
        check("abort-expiry periodic expired", 32'(per_expired), 32'd0);

        // Start with D=2 during a D=7 run must not disturb timing.
        applyStimulus(1, 0, 0, 8'd0);
        applyStimulus(0, 1, 0, 8'd7);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, (k == 2), 0, (k == 2) ? 8'd2 : 8'd0);
            check($sformatf("restart oneshot done@%0d", k),  32'(os_done),  32'(k == 8));
            check($sformatf("restart periodic done@%0d", k), 32'(per_done), 32'(k == 8));
        end

        // Reset at edge +3 of a D=7 run.
        applyStimulus(1, 0, 0, 8'd0);
        applyStimulus(0, 1, 0, 8'd7);
        applyStimulus(0, 0, 0, 8'd0);
        applyStimulus(0, 0, 0, 8'd0);
        applyStimulus(1, 1, 1, 8'd9);
        check("reset busy",    32'(os_busy),    32'd0);
        check("reset done",    32'(os_done),    32'd0);
        check("reset expired", 32'(os_expired), 32'd0);
        check("reset count",   32'(os_count),   32'd0);
        for (int k = 4; k <= 13; k++) begin
            applyStimulus(0, 0, 0, 8'd0);
            check($sformatf("post-reset done@%0d", k), 32'(os_done), 32'd0);
        end
`else
        // D=1 with a 50-cycle prescaler: count drops at +50, done at +100.
        applyStimulus(1, 0, 0, 8'd0);
        applyStimulus(0, 1, 0, 8'd1);
        for (int k = 1; k <= 101; k++) begin
            applyStimulus(0, 0, 0, 8'd0);
            if (k == 49) check("prescale count@49", 32'(os_count), 32'd1);
            if (k == 50) check("prescale count@50", 32'(os_count), 32'd0);
            if (k >= 98) check($sformatf("prescale done@%0d", k), 32'(os_done), 32'(k == 100));
        end
`endif

        // Randomized traffic against the model, including held starts and collisions.
        applyStimulus(1, 0, 0, 8'd0);
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(63) == 0);
            s = ($urandom_range(3) == 0);
            a = ($urandom_range(15) == 0);
            d = ($urandom_range(7) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(5));
            applyStimulus(r, s, a, d);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/flash_timer.md
FLASH_TIMER -- requirements
Module: flash_timer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named CLK_50MHZ and RST.
REQ-002 Parameter CNT_W SHALL default to 8 and set the delay and counter width in bits.
REQ-003 Parameter PERIODIC SHALL default to 0: 0 means one-shot, 1 means auto-reload.
REQ-004 Parameter PRESCALE SHALL default to 50 and set the clock cycles per tick; it is used only under FLASH_TIMER_PRESCALE_EN, and values below 1 are illegal.
REQ-005 CLK_50MHZ  input  1  system clock; all logic is on its rising edge.
REQ-006 RST  input  1  synchronous active-high reset.
REQ-007 start  input  1  one-cycle request to begin timing; sampled only in IDLE.
REQ-008 delay  input  CNT_W  terminal count D; sampled on the edge that accepts start.
REQ-009 abort  input  1  stops timing and returns the block to IDLE.
REQ-010 busy  output  1  high while a timing run is active.
REQ-011 done  output  1  one-cycle pulse at each expiry.
REQ-012 expired  output  1  sticky expiry flag; cleared by accepted start, abort or RST.
REQ-013 count  output  CNT_W  current down-counter value, for debug.

Function
REQ-014 The state machine SHALL have exactly two states: IDLE and RUN.
REQ-015 IDLE -> RUN: on an edge with start=1 and abort=0, count SHALL load D, busy SHALL rise and expired SHALL clear.
REQ-016 In RUN, count SHALL decrement by 1 on each tick, where a tick is every cycle (or every PRESCALE cycles, see REQ-029).
REQ-017 Expiry: on the tick where count=0, done SHALL be high in the following cycle and expired SHALL set.
- With one tick per cycle, done is high exactly D+1 edges after the accepting edge.
- D=0 is legal and gives done on the first edge after acceptance.
REQ-018 One-shot: on expiry the block SHALL return to IDLE, and busy SHALL fall on the same edge that raises done.
REQ-019 Periodic: on expiry count SHALL reload the D captured at start and stay in RUN, so busy stays high and done repeats every D+1 ticks.
REQ-020 start during RUN SHALL be ignored; there is no restart, and delay changes have no effect mid-run.
REQ-021 abort in RUN SHALL, on that edge, return the block to IDLE, drop busy, zero count, give no done, and clear expired.
REQ-022 If abort and expiry occur on the same edge, abort SHALL win: no done pulse and expired stays 0.
REQ-023 If start and abort are both high in IDLE, the block SHALL stay in IDLE.
REQ-024 start held high for several cycles SHALL be accepted once, then ignored until the block returns to IDLE.
REQ-025 A start on the same edge as a one-shot expiry SHALL be ignored, because the block is in RUN on that edge.
REQ-026 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-027 RST high on any edge SHALL force IDLE, with busy=0, done=0, expired=0, count=0 and the prescaler at 0.
REQ-028 RST SHALL override start and abort, and RST mid-run SHALL give no done pulse.

Configuration
REQ-029 Macro FLASH_TIMER_PRESCALE_EN SHALL control the prescaler.
- Defined: a PRESCALE counter cleared on accepted start generates a tick once per PRESCALE cycles, and one-shot latency is (D+1)*PRESCALE edges.
- Not defined: a tick occurs every cycle, PRESCALE is ignored and no prescaler logic is built.

Verification
REQ-030 One-shot timing: prescaler off, D=7, 1-cycle start -> busy high 8 cycles, done pulse at edge +8, expired stays 1, count reads 7..0.
REQ-031 Minimum delay: D=0 -> done at edge +1 and busy high for 1 cycle; a second start 2 cycles later -> expired clears, then sets again at the next done.
REQ-032 Periodic mode: PERIODIC=1, D=3 -> done pulses at edges +4, +8, +12; abort at +10 -> busy=0 at +10 and no pulse at +12.
REQ-033 Collisions: abort on the expiry edge -> no done, expired=0; start during RUN with D=2 against a running D=7 -> timing unchanged.
REQ-034 Reset mid-run: RST asserted at edge +3 of a D=7 run -> all outputs 0 at +3 and no done afterwards.
REQ-035 Prescaler on: FLASH_TIMER_PRESCALE_EN defined, PRESCALE=50, D=1 -> done at edge +100 and count steps every 50 cycles.
